// File: rtl/fp16_vector_quant_if.sv
// Stream bundle for the FP16 -> FP8 vector quantizer: input vector
// handshake with its format select, and the packed output handshake.
interface fp16_vector_quant_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vec;
  logic        e5m2mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_vec;

  modport master (
    output in_valid, in_vec, e5m2mode, out_ready,
    input  in_ready, out_valid, out_vec
  );

  modport slave (
    input  in_valid, in_vec, e5m2mode, out_ready,
    output in_ready, out_valid, out_vec
  );
endinterface

// File: rtl/fp16_vector_quant.sv
// Four-lane FP16 -> FP8 (E4M3 or E5M2) quantizer. Stage 1 converts and
// rounds the accepted vector, stage 2 is the packed output register.
// Saturated and NaN lanes are counted in a sticky 16-bit counter.
module fp16_vector_quant (
  input  logic                      clk,
  input  logic                      rst,
  fp16_vector_quant_if.slave        bus,
  input  logic                      sat_clear,
  output logic [15:0]               sat_count
);

  // Returns {saturated_flag, fp8_code} for one FP16 lane.
  // The value is aligned so the kept significand sits at the target
  // quantum; adding ((biased_exp - 1) << mbits) to the rounded significand
  // yields the encoding, so subnormals and rounding carries need no
  // special cases.
  function automatic logic [8:0] quant_lane(input logic [15:0] h, input logic e5m2);
    logic        sign;
    logic [4:0]  exp_in;
    logic [10:0] sig;
    logic [4:0]  te_eff;
    logic [4:0]  te_m1;
    logic [4:0]  sh;
    logic [26:0] wide;
    logic [10:0] kept;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [11:0] rounded;
    logic [11:0] enc;
    logic [6:0]  max_code;
    logic [14:0] max_mag;
    logic [7:0]  res;
    logic        is_nan;
    logic        sat;
    sign   = h[15];
    exp_in = (h[14:10] == 5'd0) ? 5'd1 : h[14:10];
    sig    = {(h[14:10] != 5'd0), h[9:0]};
    if (e5m2) begin
      // Same bias as FP16: exponent carries over, keep 2 mantissa bits.
      te_eff   = exp_in;
      sh       = 5'd8;
      max_code = 7'h7B;
      max_mag  = 15'h7B00;
    end else begin
      if (exp_in >= 5'd9) begin
        te_eff = exp_in - 5'd8;
        sh     = 5'd7;
      end else begin
        // Below E4M3 normal range: shift further into the subnormal grid.
        te_eff = 5'd1;
        sh     = 5'd7 + (5'd9 - exp_in);
      end
      max_code = 7'h7E;
      max_mag  = 15'h5F00;
    end
    te_m1   = te_eff - 5'd1;
    wide    = {sig, 16'd0} >> sh;
    kept    = wide[26:16];
    guard   = wide[15];
    sticky  = |wide[14:0];
    inc     = guard & (sticky | kept[0]);
    rounded = {1'b0, kept} + {11'd0, inc};
    if (e5m2) begin
      enc = {5'd0, te_m1, 2'd0} + rounded;
    end else begin
      enc = {4'd0, te_m1, 3'd0} + rounded;
    end
    is_nan = (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
    // Anything strictly above max finite (including Inf/NaN) counts.
    sat    = (h[14:0] > max_mag);
    if (is_nan) begin
      res = e5m2 ? 8'h7E : 8'h7F;
    end else if (enc > {5'd0, max_code}) begin
      res = {sign, max_code};
    end else begin
      res = {sign, enc[6:0]};
    end
    return {sat, res};
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_vec_q,   s1_vec_d;
  logic [2:0]  s1_sat_q,   s1_sat_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_vec_q,   s2_vec_d;
  logic [15:0] sat_count_q, sat_count_d;

  logic        advance_s;
  logic        in_ready_s;
  logic        accept_s;
  logic [8:0]  lane_res_s;
  logic [31:0] conv_vec_s;
  logic [2:0]  conv_sat_s;
  logic [16:0] sat_sum_s;

  // Convert all four incoming lanes with the mode presented alongside them.
  always_comb begin
    lane_res_s = 9'd0;
    conv_vec_s = 32'd0;
    conv_sat_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      lane_res_s             = quant_lane(bus.in_vec[16*i +: 16], bus.e5m2mode);
      conv_vec_s[8*i +: 8]   = lane_res_s[7:0];
      conv_sat_s             = conv_sat_s + {2'd0, lane_res_s[8]};
    end
  end

  // Elastic handshake, next-state of both stages and the sticky counter.
  always_comb begin
    advance_s  = !s2_valid_q || bus.out_ready;
    in_ready_s = !rst && (!s1_valid_q || advance_s);
    accept_s   = bus.in_valid && in_ready_s;

    s1_valid_d = s1_valid_q;
    s1_vec_d   = s1_vec_q;
    s1_sat_d   = s1_sat_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_vec_d   = conv_vec_s;
      s1_sat_d   = conv_sat_s;
    end else if (advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    s2_valid_d = s2_valid_q;
    s2_vec_d   = s2_vec_q;
    if (advance_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_vec_d = s1_vec_q;
      end else begin
        s2_vec_d = s2_vec_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Lanes are counted as their vector loads into the output register.
    sat_sum_s = {1'b0, sat_count_q} +
                ((advance_s && s1_valid_q) ? {14'd0, s1_sat_q} : 17'd0);
    if (sat_clear) begin
      sat_count_d = 16'd0;
    end else if (sat_sum_s[16]) begin
      sat_count_d = 16'hFFFF;
    end else begin
      sat_count_d = sat_sum_s[15:0];
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_vec_q    <= 32'd0;
      s1_sat_q    <= 3'd0;
      s2_valid_q  <= 1'b0;
      s2_vec_q    <= 32'd0;
      sat_count_q <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_vec_q    <= s1_vec_d;
      s1_sat_q    <= s1_sat_d;
      s2_valid_q  <= s2_valid_d;
      s2_vec_q    <= s2_vec_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_vec   = s2_vec_q;
  assign sat_count     = sat_count_q;

endmodule
